// File: rtl/trafik_izleyici.sv
// trafik_izleyici
// Watches the red/green/blue lines of the traffic LED sequencer, locks onto
// the red -> green -> blue -> off cycle and measures each phase in clocks.
// Phase lengths are checked against RED_CYC/GREEN_CYC/BLUE_CYC +/- TOL_CYC.
// The all-off gap between blue and red may last at most GAP_MAX cycles.
// Order and one-hot legality are checked as well.
// Errors give a one-cycle pulse, a held code and a sticky flag.
// Clean cycles are counted in a saturating 16-bit counter.
//
// Optional build macro TRAFIK_IZLEYICI_SYNC_EN: when defined, each LED input
// passes through a 2-flop synchronizer before it is sampled. This adds
// 2 cycles of latency. Phase lengths and error behaviour do not change.
//
// Error codes:
//   1 phase too short, 2 phase too long, 3 illegal sequence,
//   4 more than one LED lit, 5 off gap too long.
// Precedence inside one cycle: 4 > 3 > 1/2 > 5.
//
// The FSM state is exported on `state` so checkers can bind to it:
//   0 IDLE, 1 RED, 2 GREEN, 3 BLUE, 4 GAP.
module trafik_izleyici #(
  parameter int unsigned RED_CYC   = 220_000_000,
  parameter int unsigned GREEN_CYC = 110_000_000,
  parameter int unsigned BLUE_CYC  = 60_000_000,
  parameter int unsigned TOL_CYC   = 4,
  parameter int unsigned GAP_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        led_red,
  input  logic        led_green,
  input  logic        led_blue,
  input  logic        clr,
  output logic [2:0]  state,
  output logic        err,
  output logic [2:0]  err_code,
  output logic        err_flag,
  output logic        cycle_done,
  output logic [15:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RED   = 3'd1,
    S_GREEN = 3'd2,
    S_BLUE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  // LED patterns as {r,g,b}
  localparam logic [2:0] P_OFF   = 3'b000;
  localparam logic [2:0] P_RED   = 3'b100;
  localparam logic [2:0] P_GREEN = 3'b010;
  localparam logic [2:0] P_BLUE  = 3'b001;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_SHORT = 3'd1;
  localparam logic [2:0] E_LONG  = 3'd2;
  localparam logic [2:0] E_SEQ   = 3'd3;
  localparam logic [2:0] E_MULTI = 3'd4;
  localparam logic [2:0] E_GAP   = 3'd5;

  // Acceptance windows. A lower bound that would underflow is clamped to 0.
  localparam logic [31:0] RED_LO   = (RED_CYC   > TOL_CYC) ? RED_CYC   - TOL_CYC : 32'd0;
  localparam logic [31:0] GREEN_LO = (GREEN_CYC > TOL_CYC) ? GREEN_CYC - TOL_CYC : 32'd0;
  localparam logic [31:0] BLUE_LO  = (BLUE_CYC  > TOL_CYC) ? BLUE_CYC  - TOL_CYC : 32'd0;
  localparam logic [31:0] RED_HI   = RED_CYC   + TOL_CYC;
  localparam logic [31:0] GREEN_HI = GREEN_CYC + TOL_CYC;
  localparam logic [31:0] BLUE_HI  = BLUE_CYC  + TOL_CYC;
  localparam logic [31:0] GAP_HI   = GAP_MAX;
  localparam logic [31:0] DUR_MAX  = 32'hFFFF_FFFF;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  // Sampled pattern and its previous value
  logic [2:0]  w_p;
  logic [2:0]  r_p_q;

  // FSM and phase duration counter
  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dur;
  logic [31:0] w_dur_nxt;
  logic [31:0] w_dur_inc;

  // Per-state phase description
  logic [2:0]  w_cur_pat;
  logic [2:0]  w_next_pat;
  state_t      w_next_state;
  logic [31:0] w_lo;
  logic [31:0] w_hi;

  // Event decode
  logic        w_multi;
  logic        w_err;
  logic [2:0]  w_code;
  logic        w_done;

  // Registered outputs
  logic        r_err;
  logic [2:0]  r_err_code;
  logic        r_err_flag;
  logic        r_done;
  logic [15:0] r_cycle_cnt;

`ifdef TRAFIK_IZLEYICI_SYNC_EN
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  // Two-flop synchronizer on each LED line before sampling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {led_red, led_green, led_blue};
      r_sync2 <= r_sync1;
    end
  end

  assign w_p = r_sync2;
`else
  // Monitor shares the sequencer clock: sample the lines directly
  assign w_p = {led_red, led_green, led_blue};
`endif

  assign w_multi   = (w_p[2] & w_p[1]) | (w_p[2] & w_p[0]) | (w_p[1] & w_p[0]);
  assign w_dur_inc = (r_dur == DUR_MAX) ? r_dur : r_dur + 32'd1;

  // Describe the current phase: its own pattern, the legal successor and the window
  always_comb begin
    w_cur_pat    = P_OFF;
    w_next_pat   = P_OFF;
    w_next_state = S_IDLE;
    w_lo         = 32'd0;
    w_hi         = 32'd0;
    case (r_state)
      S_RED: begin
        w_cur_pat    = P_RED;
        w_next_pat   = P_GREEN;
        w_next_state = S_GREEN;
        w_lo         = RED_LO;
        w_hi         = RED_HI;
      end
      S_GREEN: begin
        w_cur_pat    = P_GREEN;
        w_next_pat   = P_BLUE;
        w_next_state = S_BLUE;
        w_lo         = GREEN_LO;
        w_hi         = GREEN_HI;
      end
      S_BLUE: begin
        w_cur_pat    = P_BLUE;
        w_next_pat   = P_OFF;
        w_next_state = S_GAP;
        w_lo         = BLUE_LO;
        w_hi         = BLUE_HI;
      end
      S_GAP: begin
        // The gap has no minimum; only its upper bound is checked
        w_cur_pat    = P_OFF;
        w_next_pat   = P_RED;
        w_next_state = S_RED;
        w_lo         = 32'd0;
        w_hi         = GAP_HI;
      end
      default: begin
        w_cur_pat    = P_OFF;
        w_next_pat   = P_OFF;
        w_next_state = S_IDLE;
        w_lo         = 32'd0;
        w_hi         = 32'd0;
      end
    endcase
  end

  // Next-state, duration and error decode
  always_comb begin
    w_state_nxt = r_state;
    w_dur_nxt   = r_dur;
    w_err       = 1'b0;
    w_code      = E_NONE;
    w_done      = 1'b0;
    if (r_state == S_IDLE) begin
      // Lock only on a clean off -> red edge, so a partial red is never measured
      if (r_p_q == P_OFF && w_p == P_RED) begin
        w_state_nxt = S_RED;
        w_dur_nxt   = 32'd1;
      end else begin
        w_dur_nxt   = 32'd0;
      end
    end else begin
      if (w_multi) begin
        w_err  = 1'b1;
        w_code = E_MULTI;
      end else if (w_p == w_cur_pat) begin
        // Fire as soon as the next count would leave the window
        if (r_dur >= w_hi) begin
          w_err  = 1'b1;
          w_code = (r_state == S_GAP) ? E_GAP : E_LONG;
        end else begin
          w_dur_nxt = w_dur_inc;
        end
      end else if (w_p == w_next_pat || (r_state == S_BLUE && w_p == P_RED)) begin
        if (r_dur < w_lo) begin
          w_err  = 1'b1;
          w_code = E_SHORT;
        end else begin
          // Blue may go straight to red, skipping the gap
          w_state_nxt = (w_p == P_RED) ? S_RED : w_next_state;
          w_dur_nxt   = 32'd1;
          w_done      = (w_p == P_RED);
        end
      end else begin
        w_err  = 1'b1;
        w_code = E_SEQ;
      end
      if (w_err) begin
        w_state_nxt = S_IDLE;
        w_dur_nxt   = 32'd0;
      end
    end
  end

  // FSM state, phase duration and previous-pattern registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dur   <= 32'd0;
      r_p_q   <= P_OFF;
    end else begin
      r_state <= w_state_nxt;
      r_dur   <= w_dur_nxt;
      r_p_q   <= w_p;
    end
  end

  // Error pulse, held code and sticky flag; a new error beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_err_code <= E_NONE;
      r_err_flag <= 1'b0;
    end else begin
      r_err <= w_err;
      if (w_err) begin
        r_err_code <= w_code;
        r_err_flag <= 1'b1;
      end else if (clr) begin
        r_err_code <= E_NONE;
        r_err_flag <= 1'b0;
      end
    end
  end

  // Clean-cycle pulse and saturating counter, updated on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done      <= 1'b0;
      r_cycle_cnt <= 16'd0;
    end else begin
      r_done <= w_done;
      if (w_done && r_cycle_cnt != CNT_MAX) begin
        r_cycle_cnt <= r_cycle_cnt + 16'd1;
      end
    end
  end

  assign state      = r_state;
  assign err        = r_err;
  assign err_code   = r_err_code;
  assign err_flag   = r_err_flag;
  assign cycle_done = r_done;
  assign cycle_cnt  = r_cycle_cnt;

endmodule

// File: tb/tb_trafik_izleyici.sv
// Bench for trafik_izleyici. The reference model works on runs of a constant
// LED pattern: from the current phase and the previous run length it predicts
// the transition at the start of each run and any overrun inside it.
module tb_trafik_izleyici;

  localparam int RED_CYC   = 20;
  localparam int GREEN_CYC = 10;
  localparam int BLUE_CYC  = 6;
  localparam int TOL_CYC   = 1;
  localparam int GAP_MAX   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        led_red;
  logic        led_green;
  logic        led_blue;
  logic        clr;
  logic [2:0]  state;
  logic        err;
  logic [2:0]  err_code;
  logic        err_flag;
  logic        cycle_done;
  logic [15:0] cycle_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int g_cyc    = 0;
  int obs_err_off;

  // Reference model state (phase: 0 unlocked, 1 red, 2 green, 3 blue, 4 gap)
  bit          m_locked;
  int          m_ph;
  int          m_len;
  logic [2:0]  m_prev;
  logic [15:0] m_cnt;
  logic [2:0]  m_code;
  bit          m_flag;

  typedef struct {
    logic [2:0] p;
    int         len;
    int         clr_at;
  } run_t;
  run_t rq[$];

  trafik_izleyici #(
    .RED_CYC   (RED_CYC),
    .GREEN_CYC (GREEN_CYC),
    .BLUE_CYC  (BLUE_CYC),
    .TOL_CYC   (TOL_CYC),
    .GAP_MAX   (GAP_MAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .led_red    (led_red),
    .led_green  (led_green),
    .led_blue   (led_blue),
    .clr        (clr),
    .state      (state),
    .err        (err),
    .err_code   (err_code),
    .err_flag   (err_flag),
    .cycle_done (cycle_done),
    .cycle_cnt  (cycle_cnt)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, g_cyc, obs, exp);
    end
  endtask

  // Phase rules straight from the expected lengths
  function automatic int lo_of(input int ph);
    case (ph)
      1:       return RED_CYC - TOL_CYC;
      2:       return GREEN_CYC - TOL_CYC;
      3:       return BLUE_CYC - TOL_CYC;
      default: return 0;
    endcase
  endfunction

  function automatic int hi_of(input int ph);
    case (ph)
      1:       return RED_CYC + TOL_CYC;
      2:       return GREEN_CYC + TOL_CYC;
      3:       return BLUE_CYC + TOL_CYC;
      default: return GAP_MAX;
    endcase
  endfunction

  function automatic bit legal_next(input int ph, input logic [2:0] p);
    case (ph)
      1:       return p == 3'b010;
      2:       return p == 3'b001;
      3:       return p == 3'b000 || p == 3'b100;
      4:       return p == 3'b100;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int phase_of(input logic [2:0] p);
    case (p)
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 4;
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_ph     = 0;
    m_len    = 0;
    m_prev   = 3'b000;
    m_cnt    = 16'd0;
    m_code   = 3'd0;
    m_flag   = 1'b0;
  endtask

  // Driver: one pattern for one clock, outputs checked on the falling edge
  task automatic drive_step(input logic [2:0] p, input logic c);
    {led_red, led_green, led_blue} = p;
    clr = c;
    @(posedge clk);
    @(negedge clk);
    g_cyc++;
  endtask

  // Play one run of a constant pattern and check every cycle against the model
  task automatic play_run(input logic [2:0] p, input int len, input int clr_at);
    int   trans_code;
    bit   trans_done;
    int   body_off;
    int   body_code;
    int   ph_run;
    bit   e_err;
    bit   e_done;
    int   e_state;
    trans_code  = 0;
    trans_done  = 1'b0;
    body_off    = -1;
    body_code   = 0;
    obs_err_off = -1;
    if (!m_locked) begin
      if (m_prev == 3'b000 && p == 3'b100) begin
        m_locked = 1'b1;
        m_ph     = 1;
      end
    end else begin
      if ($countones(p) > 1) trans_code = 4;
      else if (legal_next(m_ph, p)) begin
        if (m_ph != 4 && m_len < lo_of(m_ph)) trans_code = 1;
        else begin
          trans_done = (p == 3'b100);
          m_ph       = phase_of(p);
        end
      end else trans_code = 3;
      if (trans_code != 0) m_locked = 1'b0;
    end
    if (m_locked && len > hi_of(m_ph)) begin
      body_off  = hi_of(m_ph);
      body_code = (m_ph == 4) ? 5 : 2;
    end
    ph_run = m_locked ? m_ph : 0;
    for (int o = 0; o < len; o++) begin
      drive_step(p, o == clr_at);
      if (err === 1'b1 && obs_err_off < 0) obs_err_off = o;
      e_err   = (o == 0 && trans_code != 0) || (o == body_off);
      e_done  = (o == 0) && trans_done;
      e_state = (body_off >= 0 && o >= body_off) ? 0 : ph_run;
      if (e_done && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (e_err) begin
        m_code = (o == 0 && trans_code != 0) ? 3'(trans_code) : 3'(body_code);
        m_flag = 1'b1;
      end else if (o == clr_at) begin
        m_code = 3'd0;
        m_flag = 1'b0;
      end
      check("state", 32'(state), 32'(e_state));
      check("err", 32'(err), 32'(e_err));
      check("cycle_done", 32'(cycle_done), 32'(e_done));
      check("err_code", 32'(err_code), 32'(m_code));
      check("err_flag", 32'(err_flag), 32'(m_flag));
      check("cycle_cnt", 32'(cycle_cnt), 32'(m_cnt));
    end
    if (body_off >= 0) m_locked = 1'b0;
    m_len  = len;
    m_prev = p;
  endtask

  task automatic nominal_cycle();
    play_run(3'b100, RED_CYC, -1);
    play_run(3'b010, GREEN_CYC, -1);
    play_run(3'b001, BLUE_CYC, -1);
    play_run(3'b000, 1, -1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
    check({tag, "_err_flag"}, 32'(err_flag), 32'd0);
    check({tag, "_cycle_done"}, 32'(cycle_done), 32'd0);
    check({tag, "_cycle_cnt"}, 32'(cycle_cnt), 32'd0);
  endtask

  // Queue a random run, merging with the previous one if the pattern repeats
  task automatic add_run(input logic [2:0] p, input int len, input int clr_at);
    run_t r;
    if (len <= 0) return;
    if (rq.size() > 0 && rq[$].p == p) begin
      rq[$].len = rq[$].len + len;
    end else begin
      r.p      = p;
      r.len    = len;
      r.clr_at = clr_at;
      rq.push_back(r);
    end
  endtask

  function automatic int rand_len(input int e);
    if ($urandom_range(0, 3) == 0)
      return ($urandom_range(0, 1) == 0) ? e - TOL_CYC - 1 : e + TOL_CYC + 1;
    return e - TOL_CYC + int'($urandom_range(0, 2 * TOL_CYC));
  endfunction

  function automatic int rand_clr();
    return ($urandom_range(0, 9) == 0) ? 0 : -1;
  endfunction

  initial begin
    rst_n = 1'b0;
    {led_red, led_green, led_blue} = 3'b000;
    clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Nominal: three clean cycles, counted at red entries 2..4
    play_run(3'b000, 3, -1);
    repeat (3) nominal_cycle();
    play_run(3'b100, RED_CYC, -1);
    check("nominal_cnt", 32'(cycle_cnt), 32'd3);
    check("nominal_flag", 32'(err_flag), 32'd0);

    // Short green, then recovery with one more clean cycle
    play_run(3'b010, 8, -1);
    play_run(3'b001, 1, -1);
    check("short_code", 32'(err_code), 32'd1);
    check("short_flag", 32'(err_flag), 32'd1);
    check("short_state", 32'(state), 32'd0);
    play_run(3'b000, 2, -1);
    nominal_cycle();
    play_run(3'b100, RED_CYC, -1);
    check("short_recover_cnt", 32'(cycle_cnt), 32'd4);

    // Long red: error on the 22nd red cycle
    play_run(3'b010, GREEN_CYC, -1);
    play_run(3'b001, BLUE_CYC, -1);
    play_run(3'b000, 2, -1);
    play_run(3'b100, 25, -1);
    check("long_offset", 32'(obs_err_off), 32'd21);
    check("long_code", 32'(err_code), 32'd2);

    // Sequence error and multi-LED error
    play_run(3'b000, 2, -1);
    play_run(3'b100, RED_CYC, -1);
    play_run(3'b001, 2, -1);
    check("seq_code", 32'(err_code), 32'd3);
    play_run(3'b000, 2, -1);
    play_run(3'b100, RED_CYC, -1);
    play_run(3'b010, 5, -1);
    play_run(3'b110, 1, -1);
    check("multi_code", 32'(err_code), 32'd4);
    check("multi_state", 32'(state), 32'd0);

    // Gap timeout, then clear, then clear coincident with a new error
    play_run(3'b000, 2, -1);
    play_run(3'b100, RED_CYC, -1);
    play_run(3'b010, GREEN_CYC, -1);
    play_run(3'b001, BLUE_CYC, -1);
    play_run(3'b000, 8, 6);
    check("clr_flag", 32'(err_flag), 32'd0);
    check("clr_code", 32'(err_code), 32'd0);
    play_run(3'b100, RED_CYC, -1);
    play_run(3'b001, 1, 0);
    check("clr_err_flag", 32'(err_flag), 32'd1);
    check("clr_err_code", 32'(err_code), 32'd3);

    // Reset in the middle of green; a partial red afterwards is ignored
    play_run(3'b000, 2, -1);
    play_run(3'b100, RED_CYC, -1);
    play_run(3'b010, 4, -1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    play_run(3'b010, 5, -1);
    play_run(3'b001, BLUE_CYC, -1);
    play_run(3'b100, 12, -1);
    play_run(3'b000, 2, -1);
    nominal_cycle();
    play_run(3'b100, RED_CYC, -1);
    check("after_reset_cnt", 32'(cycle_cnt), 32'd1);

    // Saturation: preload the counter, one more clean cycle must hold it
    force dut.r_cycle_cnt = 16'hFFFF;
    #1 release dut.r_cycle_cnt;
    m_cnt = 16'hFFFF;
    play_run(3'b010, GREEN_CYC, -1);
    play_run(3'b001, BLUE_CYC, -1);
    play_run(3'b000, 1, -1);
    play_run(3'b100, 3, -1);
    check("sat_cnt", 32'(cycle_cnt), 32'hFFFF);

    // Randomized runs around the window edges, with stray patterns and clears
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    add_run(3'b000, 2, -1);
    for (int k = 0; k < 15; k++) begin
      add_run(3'b100, rand_len(RED_CYC), rand_clr());
      if ($urandom_range(0, 7) == 0) add_run(3'($urandom_range(0, 7)), int'($urandom_range(1, 2)), -1);
      add_run(3'b010, rand_len(GREEN_CYC), rand_clr());
      if ($urandom_range(0, 7) == 0) add_run(3'($urandom_range(0, 7)), int'($urandom_range(1, 2)), -1);
      add_run(3'b001, rand_len(BLUE_CYC), rand_clr());
      add_run(3'b000, int'($urandom_range(0, GAP_MAX + 1)), rand_clr());
    end
    while (rq.size() > 0) begin
      run_t r;
      r = rq.pop_front();
      play_run(r.p, r.len, r.clr_at);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
